axi_lite_shadow_regs: RTL and testbench

- Parametrised AXI-Lite slave register file for ray-tracer configuration: camera position/direction/basis vectors and image size.
- Supersedes the fixed 8-entry regfile inside the pixel generator.
- Adds byte strobes, read-only status registers, address/permission error responses, and shadow/active double-buffering committed only at start of frame, so the RayTracingUnit never sees a half-updated camera.

---
 rtl/axi_lite_shadow_regs.sv | 168 ++++++++++++++++
 tb/tb_axi_lite_shadow_regs.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_shadow_regs.sv
// axi_lite_shadow_regs: AXI-Lite shadow/active register file committed on frame_sof; define AXI_LITE_SHADOW_REGS_IRQ_EN to add commit_irq
module axi_lite_shadow_regs #(
  parameter int NUM_REGS = 16,
  parameter int NUM_RO = 2,
  parameter int AXI_LITE_ADDR_WIDTH = 8
) (
  input  logic                           s_axi_lite_aclk,
  input  logic                           axi_resetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic [3:0]                     s_axi_lite_wstrb,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  input  logic                           frame_sof,
  input  logic [32*NUM_RO-1:0]           status_in,
  output logic [32*NUM_REGS-1:0]         regs_active,
`ifdef AXI_LITE_SHADOW_REGS_IRQ_EN
  output logic                           commit_irq,
  output logic                           commit_pending
`else
  output logic                           commit_pending
`endif
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int AW = AXI_LITE_ADDR_WIDTH;
  localparam int RW = NUM_REGS - NUM_RO;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
  wstate_t wst_q;
  rstate_t rst_q;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q, pend_q, pend_d;
  logic [1:0] bresp_q, rresp_q;
  logic [AW-1:0] awaddr_q, wr_addr;
  logic [31:0] wdata_q, wr_data, rdata_q, rd_data;
  logic [3:0] wstrb_q, wr_strb;
  logic [31:0] shadow_q [1:RW-1];
  logic [31:0] active_q [1:RW-1];
  logic [IW-1:0] wr_idx, ar_idx;
  logic wr_fire, wr_oor, wr_err, wr_we, ar_fire, ar_oor, commit, ctrl_set;
  logic unused_addr;
  assign unused_addr = ^{wr_addr[1:0], s_axi_lite_araddr[1:0]};
  assign wr_fire = (wst_q == W_IDLE && s_axi_lite_awvalid && s_axi_lite_wvalid)
                || (wst_q == W_ADDR && s_axi_lite_wvalid)
                || (wst_q == W_DATA && s_axi_lite_awvalid);
  assign wr_addr = wst_q == W_ADDR ? awaddr_q : s_axi_lite_awaddr;
  assign wr_data = wst_q == W_DATA ? wdata_q : s_axi_lite_wdata;
  assign wr_strb = wst_q == W_DATA ? wstrb_q : s_axi_lite_wstrb;
  assign wr_idx = wr_addr[2+:IW];
  assign wr_oor = 32'(wr_addr[AW-1:2]) >= 32'(NUM_REGS);
  assign wr_err = wr_oor || int'(wr_idx) >= RW;
  assign wr_we = wr_fire && !wr_err;
  assign ctrl_set = wr_we && wr_idx == '0 && wr_strb[0] && wr_data[0];
  assign commit = frame_sof && pend_q;
  assign pend_d = ctrl_set || (pend_q && !frame_sof);
  assign ar_fire = rst_q == R_IDLE && s_axi_lite_arvalid;
  assign ar_idx = s_axi_lite_araddr[2+:IW];
  assign ar_oor = 32'(s_axi_lite_araddr[AW-1:2]) >= 32'(NUM_REGS);
  always_comb begin
    rd_data = '0;
    for (int k = 1; k < RW; k++) if (int'(ar_idx) == k) rd_data = shadow_q[k];
    for (int k = 0; k < NUM_RO; k++) if (int'(ar_idx) == RW + k) rd_data = status_in[32*k+:32];
    if (ar_idx == '0) rd_data = {31'b0, pend_q};
    if (ar_oor) rd_data = '0;
  end
  always_ff @(posedge s_axi_lite_aclk) begin
    if (!axi_resetn) begin
      wst_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q <= 1'b1;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (wr_fire) begin
      wst_q <= W_RESP;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q <= wr_err ? 2'b10 : 2'b00;
    end else if (wst_q == W_IDLE && s_axi_lite_awvalid) begin
      wst_q <= W_ADDR;
      awready_q <= 1'b0;
      awaddr_q <= s_axi_lite_awaddr;
    end else if (wst_q == W_IDLE && s_axi_lite_wvalid) begin
      wst_q <= W_DATA;
      wready_q <= 1'b0;
      wdata_q <= s_axi_lite_wdata;
      wstrb_q <= s_axi_lite_wstrb;
    end else if (wst_q == W_RESP && s_axi_lite_bready) begin
      wst_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q <= 1'b1;
      bvalid_q <= 1'b0;
    end
  end
  always_ff @(posedge s_axi_lite_aclk) begin
    if (!axi_resetn) begin
      rst_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else if (ar_fire) begin
      rst_q <= R_RESP;
      arready_q <= 1'b0;
      rvalid_q <= 1'b1;
      rdata_q <= rd_data;
      rresp_q <= ar_oor ? 2'b10 : 2'b00;
    end else if (rst_q == R_RESP && s_axi_lite_rready) begin
      rst_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q <= 1'b0;
    end
  end
  always_ff @(posedge s_axi_lite_aclk) begin
    if (!axi_resetn) begin
      pend_q <= 1'b0;
      for (int k = 1; k < RW; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int k = 1; k < RW; k++) begin
        if (commit) active_q[k] <= shadow_q[k];
        for (int b = 0; b < 4; b++)
          if (wr_we && int'(wr_idx) == k && wr_strb[b]) shadow_q[k][8*b+:8] <= wr_data[8*b+:8];
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_act
    if (i >= 1 && i < RW) begin : g_rw
      assign regs_active[32*i+:32] = active_q[i];
    end else begin : g_zero
      assign regs_active[32*i+:32] = '0;
    end
  end
`ifdef AXI_LITE_SHADOW_REGS_IRQ_EN
  logic irq_q;
  always_ff @(posedge s_axi_lite_aclk) begin
    if (!axi_resetn) irq_q <= 1'b0;
    else irq_q <= commit;
  end
  assign commit_irq = irq_q;
`endif
  assign s_axi_lite_awready = awready_q;
  assign s_axi_lite_wready = wready_q;
  assign s_axi_lite_bvalid = bvalid_q;
  assign s_axi_lite_bresp = bresp_q;
  assign s_axi_lite_arready = arready_q;
  assign s_axi_lite_rvalid = rvalid_q;
  assign s_axi_lite_rdata = rdata_q;
  assign s_axi_lite_rresp = rresp_q;
  assign commit_pending = pend_q;
endmodule

// File: tb/tb_axi_lite_shadow_regs.sv
// tb_axi_lite_shadow_regs: scoreboard bench with a high-level register-file model
module tb_axi_lite_shadow_regs;
  localparam int NR = 16;
  localparam int NRO = 2;
  localparam int RW = NR - NRO;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1, frame_sof = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid, commit_pending;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [63:0] status = '0;
  logic [32*NR-1:0] regs_active;
`ifdef AXI_LITE_SHADOW_REGS_IRQ_EN
  logic commit_irq;
`endif
  int checks = 0;
  int errors = 0;
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  logic [31:0] sh_m [NR];
  logic [31:0] act_m [NR];
  bit pend_m = 1'b0;
  logic [1:0] b_exp;
  logic [33:0] r_exp;

  always #5 clk = ~clk;

  axi_lite_shadow_regs dut (
    .s_axi_lite_aclk(clk), .axi_resetn(rstn),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
    .frame_sof(frame_sof), .status_in(status), .regs_active(regs_active),
`ifdef AXI_LITE_SHADOW_REGS_IRQ_EN
    .commit_irq(commit_irq),
`endif
    .commit_pending(commit_pending)
  );

  task automatic chk(input string name, input logic [32*NR-1:0] act, input logic [32*NR-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32*NR-1:0] act_vec();
    logic [32*NR-1:0] v = '0;
    for (int i = 1; i < RW; i++) v[32*i+:32] = act_m[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      sh_m[i] = '0;
      act_m[i] = '0;
    end
    pend_m = 1'b0;
  endtask

  task automatic commit_m();
    for (int i = 1; i < RW; i++) act_m[i] = sh_m[i];
    pend_m = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rstn && bvalid && bready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got bresp %b expected no response", bresp);
      end else begin
        b_exp = bq.pop_front();
        if (bresp !== b_exp) begin
          errors++;
          $display("FAIL bresp: got %b expected %b", bresp, b_exp);
        end
      end
    end
    if (rstn && rvalid && rready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got %h/%b expected no response", rdata, rresp);
      end else begin
        r_exp = rq.pop_front();
        if ({rdata, rresp} !== r_exp) begin
          errors++;
          $display("FAIL rdata_rresp: got %h/%b expected %h/%b", rdata, rresp, r_exp[33:2], r_exp[1:0]);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    bready = ($urandom % 4) != 0;
    rready = ($urandom % 4) != 0;
  end

  task automatic hs(input bit aw, input bit w);
    bit done = 1'b0;
    awvalid = aw;
    wvalid = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((!aw || awready) && (!w || wready)) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    frame_sof = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no ready expected ready within 50 cycles");
    end
  endtask

  task automatic wait_b();
    for (int i = 0; i < 100 && bq.size() != 0; i++) @(posedge clk);
    #1;
    if (bq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL b_timeout: got no bvalid handshake expected one");
      bq.delete();
    end
  endtask

  task automatic wait_r();
    for (int i = 0; i < 100 && rq.size() != 0; i++) @(posedge clk);
    #1;
    if (rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL r_timeout: got no rvalid handshake expected one");
      rq.delete();
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int mode, input int dly, input bit sof);
    int idx = int'(a[7:2]);
    bit err = idx >= RW;
    if (sof && pend_m) commit_m();
    if (!err && idx == 0 && s[0] && d[0]) pend_m = 1'b1;
    if (!err && idx != 0)
      for (int b = 0; b < 4; b++) if (s[b]) sh_m[idx][8*b+:8] = d[8*b+:8];
    bq.push_back(err ? 2'b10 : 2'b00);
    awaddr = a;
    wdata = d;
    wstrb = s;
    if (mode == 0) begin
      frame_sof = sof;
      hs(1'b1, 1'b1);
    end else if (mode == 1) begin
      hs(1'b0, 1'b1);
      repeat (dly) begin @(posedge clk); #1; end
      hs(1'b1, 1'b0);
    end else begin
      hs(1'b1, 1'b0);
      repeat (dly) begin @(posedge clk); #1; end
      hs(1'b0, 1'b1);
    end
    chk("bvalid_latency", bvalid, 1'b1);
    wait_b();
  endtask

  task automatic rd(input logic [7:0] a);
    int idx = int'(a[7:2]);
    logic [31:0] d;
    if (idx >= NR) d = '0;
    else if (idx == 0) d = {31'b0, pend_m};
    else if (idx >= RW) d = status[32*(idx-RW)+:32];
    else d = sh_m[idx];
    rq.push_back({d, idx >= NR ? 2'b10 : 2'b00});
    araddr = a;
    arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) break;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    wait_r();
  endtask

  task automatic sof_pulse();
    bit c = pend_m;
    if (pend_m) commit_m();
    frame_sof = 1'b1;
    @(posedge clk);
    #1;
    frame_sof = 1'b0;
    chk("active_after_sof", regs_active, act_vec());
    chk("pending_after_sof", commit_pending, pend_m);
`ifdef AXI_LITE_SHADOW_REGS_IRQ_EN
    chk("irq_pulse", commit_irq, c);
    @(posedge clk);
    #1;
    chk("irq_clear", commit_irq, 1'b0);
`else
    if (c) chk("active_hold", regs_active, act_vec());
`endif
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_awready"}, awready, 1'b1);
    chk({tag, "_wready"}, wready, 1'b1);
    chk({tag, "_arready"}, arready, 1'b1);
    chk({tag, "_bvalid"}, bvalid, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_active"}, regs_active, '0);
    chk({tag, "_pending"}, commit_pending, 1'b0);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle_checks("reset");
    wr(8'h0C, 32'h0000_00E6, 4'hF, 0, 0, 1'b0);
    rd(8'h0C);
    chk("slot3_before_commit", regs_active, act_vec());
    wr(8'h00, 32'h1, 4'h1, 0, 0, 1'b0);
    chk("pending_set", commit_pending, 1'b1);
    sof_pulse();
    chk("slot3_committed", regs_active[3*32+:32], 32'h0000_00E6);
    wr(8'h0C, 32'h0000_AB00, 4'b0010, 1, 3, 1'b0);
    rd(8'h0C);
    wr(8'h38, 32'hDEAD_BEEF, 4'hF, 2, 2, 1'b0);
    rd(8'h40);
    status = {32'hCAFE_0001, 32'h1234_5678};
    rd(8'h38);
    rd(8'h3C);
    wr(8'h00, 32'hFFFF_FFFE, 4'hF, 0, 0, 1'b0);
    chk("ctrl_bit0_zero", commit_pending, 1'b0);
    for (int n = 0; n < 80; n++) begin
      int op = int'($urandom % 5);
      if (op < 2) begin
        logic [7:0] a = {1'b0, 5'($urandom_range(0, 17)), 2'b00};
        logic [31:0] d = $urandom;
        int mode = int'($urandom % 3);
        wr(a, d, 4'($urandom), mode, int'($urandom % 4), mode == 0 && ($urandom % 5) == 0);
      end else if (op == 2) begin
        status = {$urandom, $urandom};
        rd({1'b0, 5'($urandom_range(0, 17)), 2'b00});
      end else if (op == 3) begin
        sof_pulse();
      end else begin
        chk("rand_pending", commit_pending, pend_m);
        chk("rand_active", regs_active, act_vec());
      end
    end
    sof_pulse();
    wr(8'h00, 32'h1, 4'h1, 0, 0, 1'b1);
    chk("coincident_ctrl_no_copy", regs_active, act_vec());
    chk("coincident_ctrl_pending", commit_pending, 1'b1);
    wr(8'h10, 32'h5555_AAAA, 4'hF, 0, 0, 1'b1);
    chk("coincident_rw_preserves", regs_active, act_vec());
    rd(8'h10);
    wr(8'h00, 32'h1, 4'h1, 0, 0, 1'b0);
    sof_pulse();
    chk("slot4_next_commit", regs_active[4*32+:32], 32'h5555_AAAA);
    wr(8'h00, 32'h1, 4'h1, 0, 0, 1'b0);
    awaddr = 8'h14;
    hs(1'b1, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_clear();
    bq.delete();
    rq.delete();
    idle_checks("midreset");
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_bvalid", bvalid, 1'b0);
    rd(8'h14);
    rd(8'h0C);
    wr(8'h14, 32'h0BAD_F00D, 4'hF, 0, 0, 1'b0);
    rd(8'h14);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1, "timeout");
  end
endmodule
